// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling FSM (8N1, LSB first)
// feeding a 4-entry byte FIFO with ready/valid read side and error pulses.
module uart_rx_ctrl #(
  parameter int CLK_PER_BIT = 5200,
  parameter int SIZE        = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] fifo_count,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [SIZE-1:0] BIT_END  = SIZE'(CLK_PER_BIT - 1);
  localparam logic [SIZE-1:0] HALF_END = SIZE'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e          state_q;
  logic [SIZE-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic            frame_err_q;
  logic            rxd_meta_q;
  logic            rxd_s_q;
  logic            rxd_prev_q;

  logic [7:0]      mem_q [4];
  logic [1:0]      rd_ptr_q;
  logic [1:0]      wr_ptr_q;
  logic [2:0]      count_q;
  logic            overrun_q;

  logic            stop_sample_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            wr_en_s;
  logic [2:0]      count_d;

  // Line synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  // Receive FSM: half-bit start check, then one sample per bit period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rxd_prev_q && !rxd_s_q) begin
            state_q <= ST_START;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_END) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            // A line already back high at mid-start was a glitch.
            state_q <= rxd_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + SIZE'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_END) begin
            shreg_q[idx_q] <= rxd_s_q;
            cnt_q          <= '0;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q + SIZE'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            frame_err_q <= !rxd_s_q;
          end else begin
            cnt_q <= cnt_q + SIZE'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // FIFO control: a pop frees the head slot, so a full FIFO still accepts a same-cycle push.
  always_comb begin
    stop_sample_s = (state_q == ST_STOP) && (cnt_q == BIT_END);
    push_s        = stop_sample_s && rxd_s_q;
    pop_s         = rx_valid && rx_ready;
    full_s        = (count_q == 3'd4);
    wr_en_s       = push_s && (!full_s || pop_s);
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and overrun pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q   <= count_d;
      overrun_q <= push_s && full_s && !pop_s;
    end
  end

  assign rx_valid   = (count_q != 3'd0);
  assign rx_data    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
